// File: rtl/iso14443a_pkg.sv
// Shared ISO 14443-A definitions: routing FSM states and the default
// pending-change timeout.
package iso14443a_pkg;

  localparam int unsigned PENDING_TIMEOUT_DEFAULT = 8192;

  typedef enum logic [1:0] {
    RS_INIT,
    RS_PEND_4,
    RS_PART4,
    RS_PEND_INIT
  } RoutingState;

  // True in either state that waits for a response Tx to finish
  function automatic logic is_pend(input RoutingState s);
    return (s == RS_PEND_4) || (s == RS_PEND_INIT);
  endfunction

  // True in states where Rx/Tx belong to the 14443-4 layer
  function automatic logic routes_to_4(input RoutingState s);
    return (s == RS_PART4) || (s == RS_PEND_INIT);
  endfunction

endpackage

// File: rtl/routing_ctrl_if.sv
// Frame strobes, protocol events and routing controls of routing_ctrl.
// master: drives strobes/events, receives routes. slave: the controller.
interface routing_ctrl_if;
  logic rx_soc;
  logic rx_eoc;
  logic rx_error;
  logic tx_busy;
  logic rats_done;
  logic deselect_done;
  logic force_init;
  logic route_rx_to_initialisation;
  logic route_rx_to_14443_4;
  logic route_tx_from_14443_4;
  logic pending;

  modport master (
    output rx_soc, rx_eoc, rx_error, tx_busy, rats_done, deselect_done, force_init,
    input  route_rx_to_initialisation, route_rx_to_14443_4, route_tx_from_14443_4, pending
  );

  modport slave (
    input  rx_soc, rx_eoc, rx_error, tx_busy, rats_done, deselect_done, force_init,
    output route_rx_to_initialisation, route_rx_to_14443_4, route_tx_from_14443_4, pending
  );
endinterface

// File: rtl/routing_ctrl_frame_tracker.sv
// frame_tracker: tracks whether an Rx frame is in progress and whether a
// Tx has started since the last pending-change entry.
module frame_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_soc_i,
  input  logic rx_eoc_i,
  input  logic rx_error_i,
  input  logic tx_busy_i,
  input  logic tx_clr_i,
  output logic in_frame_o,
  output logic tx_seen_o
);

  logic in_frame_q, in_frame_d;
  logic tx_seen_q, tx_seen_d;

  // End of frame wins over start so a same-cycle soc/eoc leaves no frame open
  always_comb begin
    in_frame_d = in_frame_q;
    if (rx_eoc_i || rx_error_i) begin
      in_frame_d = 1'b0;
    end else if (rx_soc_i) begin
      in_frame_d = 1'b1;
    end
    tx_seen_d = tx_seen_q;
    if (tx_clr_i) begin
      tx_seen_d = 1'b0;
    end else if (tx_busy_i) begin
      tx_seen_d = 1'b1;
    end
  end

  // Flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_q <= 1'b0;
      tx_seen_q  <= 1'b0;
    end else begin
      in_frame_q <= in_frame_d;
      tx_seen_q  <= tx_seen_d;
    end
  end

  assign in_frame_o = in_frame_q;
  assign tx_seen_o  = tx_seen_q;

endmodule

// File: rtl/routing_ctrl.sv
// routing_ctrl: switches Rx/Tx routing between the initialisation layer and
// the 14443-4 layer, committing a change only once its response Tx has gone
// out and no Rx frame is active.
// Optional: define ROUTING_CTRL_PEND_TIMEOUT_EN to cancel a pending change
// that sees no Tx within PENDING_TIMEOUT cycles.
module routing_ctrl
  import iso14443a_pkg::*;
#(
  parameter int unsigned PENDING_TIMEOUT = PENDING_TIMEOUT_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  routing_ctrl_if.slave rc
);

  RoutingState state_q, state_d;
  logic        in_frame;
  logic        tx_seen;
  logic        tx_clr;
  logic        timeout_hit;
  logic        route_init_q;
  logic        route_4_q;
  logic        pending_q;

  frame_tracker u_frame_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_soc_i   (rc.rx_soc),
    .rx_eoc_i   (rc.rx_eoc),
    .rx_error_i (rc.rx_error),
    .tx_busy_i  (rc.tx_busy),
    .tx_clr_i   (tx_clr),
    .in_frame_o (in_frame),
    .tx_seen_o  (tx_seen)
  );

`ifdef ROUTING_CTRL_PEND_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LOAD = 16'(PENDING_TIMEOUT);
  logic [15:0] cnt_q, cnt_d;

  // Reload on pending entry, count down while waiting for Tx, stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (tx_clr) begin
      cnt_d = TIMEOUT_LOAD;
    end else if (is_pend(state_q) && !tx_seen && (cnt_q != '0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= TIMEOUT_LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the edge at which the counter reaches zero
  assign timeout_hit = is_pend(state_q) && !tx_seen && (cnt_q <= 16'd1);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next state: force_init first, then commit, then cancel
  always_comb begin
    state_d = state_q;
    if (rc.force_init) begin
      if (!in_frame && !rc.tx_busy) begin
        state_d = RS_INIT;
      end
    end else begin
      case (state_q)
        RS_INIT:   if (rc.rats_done)     state_d = RS_PEND_4;
        RS_PART4:  if (rc.deselect_done) state_d = RS_PEND_INIT;
        RS_PEND_4: begin
          if (tx_seen && !rc.tx_busy && !in_frame) begin
            state_d = RS_PART4;
          end else if (!tx_seen && (rc.rx_soc || timeout_hit)) begin
            state_d = RS_INIT;
          end
        end
        RS_PEND_INIT: begin
          if (tx_seen && !rc.tx_busy && !in_frame) begin
            state_d = RS_INIT;
          end else if (!tx_seen && (rc.rx_soc || timeout_hit)) begin
            state_d = RS_PART4;
          end
        end
        default: state_d = RS_INIT;
      endcase
    end
  end

  assign tx_clr = is_pend(state_d) && !is_pend(state_q);

  // State and routing registers, outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RS_INIT;
      route_init_q <= 1'b1;
      route_4_q    <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      route_init_q <= !routes_to_4(state_d);
      route_4_q    <= routes_to_4(state_d);
      pending_q    <= is_pend(state_d);
    end
  end

  assign rc.route_rx_to_initialisation = route_init_q;
  assign rc.route_rx_to_14443_4        = route_4_q;
  assign rc.route_tx_from_14443_4      = route_4_q;
  assign rc.pending                    = pending_q;

endmodule
